// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: MIPS funct codes and FSM states.
package mdu_pkg;

  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MTLO  = 6'b010011;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } mduStateT;

  function automatic logic isMdOp(input logic [5:0] f);
    return (f == FN_MULT) || (f == FN_MULTU) || (f == FN_DIV) || (f == FN_DIVU);
  endfunction

endpackage

// File: rtl/mdu.sv
// Iterative MIPS HI/LO multiply/divide unit: one radix-2 step per cycle on a
// shared 2*WIDTH+1-bit shift/accumulate register, sign fixed up at the end.
module mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic [5:0]       func,
  input  logic [WIDTH-1:0] valA,
  input  logic [WIDTH-1:0] valB,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int ACC_W = 2 * WIDTH + 1;

  mduStateT         state;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] acc;
  logic [WIDTH-1:0] magB;
  logic             isDiv;
  logic             negA;
  logic             negB;
  logic             divZero;

  function automatic logic [WIDTH-1:0] absVal(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] applySign(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] applySignWide(input logic [2*WIDTH-1:0] v,
                                                       input logic neg);
    return neg ? -v : v;
  endfunction

  logic opSigned;
  assign opSigned = (func == FN_MULT) || (func == FN_DIV);

  // Multiply: acc = {carry, partial product, remaining multiplier bits}.
  // Divide:   acc = {partial remainder, remaining dividend / quotient bits}.
  logic [WIDTH:0]   mulSum;
  logic [WIDTH:0]   remShift;
  logic [WIDTH:0]   remNext;
  logic             qBit;
  logic [ACC_W-1:0] accStep;

  always_comb begin
    mulSum   = acc[ACC_W-1:WIDTH] + (acc[0] ? {1'b0, magB} : '0);
    remShift = acc[2*WIDTH-1:WIDTH-1];
    qBit     = (remShift >= {1'b0, magB});
    remNext  = qBit ? (remShift - {1'b0, magB}) : remShift;
    if (isDiv) accStep = {remNext, acc[WIDTH-2:0], qBit};
    else       accStep = {1'b0, mulSum, acc[WIDTH-1:1]};
  end

  // A zero divisor leaves the quotient all ones and the remainder equal to the
  // dividend; re-applying the dividend sign restores the original valA.
  logic [2*WIDTH-1:0] prodFix;
  logic [WIDTH-1:0]   quoFix;
  logic [WIDTH-1:0]   remFix;

  always_comb begin
    prodFix = applySignWide(acc[2*WIDTH-1:0], negA ^ negB);
    quoFix  = divZero ? '1 : applySign(acc[WIDTH-1:0], negA ^ negB);
    remFix  = applySign(acc[2*WIDTH-1:WIDTH], negA);
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      acc     <= '0;
      magB    <= '0;
      isDiv   <= 1'b0;
      negA    <= 1'b0;
      negB    <= 1'b0;
      divZero <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start && isMdOp(func)) begin
              isDiv   <= (func == FN_DIV) || (func == FN_DIVU);
              negA    <= opSigned && valA[WIDTH-1];
              negB    <= opSigned && valB[WIDTH-1];
              divZero <= (valB == '0);
              magB    <= absVal(valB, opSigned);
              acc     <= {{(WIDTH+1){1'b0}}, absVal(valA, opSigned)};
              cnt     <= '0;
              state   <= CALC;
            end else if (start && func == FN_MTHI) begin
              hi <= valA;
            end else if (start && func == FN_MTLO) begin
              lo <= valA;
            end
          end
          CALC: begin
            acc <= accStep;
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(WIDTH - 1)) state <= FINISH;
          end
          FINISH: begin
            if (isDiv) begin
              hi <= remFix;
              lo <= quoFix;
            end else begin
              {hi, lo} <= prodFix;
            end
            done  <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
